z80_intctl_nch: RTL
===================

Name: z80_intctl_nch

Overview:
- N-channel, parametrised Z80 IM2 interrupt controller; successor to the 3-channel fixed controller.
- Captures single-cycle request strobes from peripherals. Per-channel enable and request registers are CPU-writable.
- Drives INT_n and returns an 8-bit IM2 vector during INTACK.
- New capability: in-service tracking with EOI, so a lower-or-equal priority source cannot interrupt a handler in progress.

Parameters:
- NCH, 8, number of channels (2..16); channel 0 is highest priority.
- VEC_BASE, 8'h80, vector for channel 0; channel i yields VEC_BASE+2*i; spurious yields VEC_BASE+2*NCH. Must not exceed 8'hFF.
- NEST, 1, 1 = in-service masking active; 0 = isr register held at 0, no masking.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- m1_n  in  1  Z80 M1, asynchronous
- iorq_n  in  1  Z80 IORQ, asynchronous
- int_n  out  1  registered interrupt request to CPU
- int_vector  out  8  IM2 vector for the latched winner
- int_stbs  in  NCH  request strobes, one clk wide, active-high
- ena_wr  in  1  write enable register
- req_wr  in  1  write request register
- eoi_wr  in  1  end-of-interrupt
- wr_mask  in  NCH  channel select for writes
- wr_set  in  1  value written to selected bits (ena_wr/req_wr)
- ena_rd  out  NCH  enable readback
- req_rd  out  NCH  request readback
- isr_rd  out  NCH  in-service readback

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. All state is on the posedge of clk.
- Reset values:
  - ena = 1 (channel 0 only); req = 0; isr = 0
  - int_n = 1
  - winner = spurious, so int_vector = VEC_BASE+2*NCH
  - sync flops = 1
- Synchronisation:
  - m1_n and iorq_n each pass through 2 flops (m1_r→m1_rr, iorq_r→iorq_rr).
  - m1_beg = m1_rr & !m1_r.
  - iorq_beg = iorq_rr & !iorq_r.
  - ack = iorq_beg & !m1_rr.
- Blocking mask:
  - blk[i] = 1 when NEST=1 and any isr[j] is set with j <= i.
  - pend = req & ena & ~blk.
- int_n: int_n <= !(|pend) every cycle. Latency is 1 clk from req/ena/isr change to int_n.
- Arbitration:
  - On m1_beg, latch winner = lowest index set in pend, or spurious if pend == 0.
  - Winner holds until the next m1_beg.
  - int_vector is combinational from winner: VEC_BASE+2*idx, or VEC_BASE+2*NCH if spurious.
- Per-bit priority for req[i], highest first:
  - int_stbs[i] → 1
  - ack & winner==i → 0
  - req_wr & wr_mask[i] → wr_set
  - otherwise hold.
- Per-bit priority for isr[i] (NEST=1):
  - ack & winner==i → 1
  - eoi_wr → clear
  - otherwise hold.
- EOI:
  - If wr_mask != 0, clear isr bits where wr_mask is 1.
  - If wr_mask == 0, clear the lowest-index set isr bit (the handler currently in service).
- ena: on ena_wr, ena[i] <= wr_set for each i with wr_mask[i]=1.
- Spurious ack (winner spurious): no req or isr change.
- Disabling a channel leaves its req pending; re-enabling re-asserts int_n after 1 clk.
- A strobe arriving while the same channel is in service sets req. It stays pending until the EOI unblocks it.
- Simultaneous ena_wr and req_wr are both applied.
- Asserting rst_n mid-INTACK returns everything to reset values. A half-seen IORQ edge after release does not ack, because the sync flops reset high.

Test Plan:
- Reset, then strobe int_stbs=8'h01 at cycle 5 → req_rd=01 at cycle 6, int_n=0 at cycle 7. M1 low then IORQ low → int_vector=8'h80, req_rd=00, isr_rd=01, int_n returns to 1.
- ena all 1 (ena_wr, wr_mask=FF, wr_set=1). Strobe 8'h28 → vector 8'h86 (ch3). After ack, ch5 is still pending and int_n stays 1 because it is blocked by isr[3]. eoi_wr with wr_mask=00 → isr=00, int_n=0 in 1 clk. Next ack → vector 8'h8A.
- Nesting: ch4 in service, then strobe ch1 → int_n=0, ack gives vector 8'h82, isr_rd=8'h12. EOI with mask=0 clears bit 1 only → isr_rd=8'h10.
- Same-cycle strobe and ack-clear on ch2 → req[2] stays 1. Same-cycle req_wr clear and strobe → req stays 1.
- M1 falling with pend=0, then IORQ → int_vector=8'h90 (NCH=8), no state change. Also repeat with NCH=16, VEC_BASE=8'h00: ch15 yields 8'h1E.
- rst_n pulse during iorq_n low with req=FF → all registers at reset values, int_n=1. IORQ rising then falling after reset is a normal ack only if m1 is low.

Source files
------------

// File: rtl/z80_intctl_nch.sv
// N-channel Z80 IM2 interrupt controller with in-service tracking and EOI.
// Channel 0 has the highest priority. A channel that is in service blocks itself
// and every lower-priority channel until an EOI clears it.
module z80_intctl_nch #(
    parameter int unsigned NCH      = 8,
    parameter logic [7:0]  VEC_BASE = 8'h80,
    parameter bit          NEST     = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           m1_n,
    input  logic           iorq_n,
    output logic           int_n,
    output logic [7:0]     int_vector,
    input  logic [NCH-1:0] int_stbs,
    input  logic           ena_wr,
    input  logic           req_wr,
    input  logic           eoi_wr,
    input  logic [NCH-1:0] wr_mask,
    input  logic           wr_set,
    output logic [NCH-1:0] ena_rd,
    output logic [NCH-1:0] req_rd,
    output logic [NCH-1:0] isr_rd
);
    localparam int unsigned IW       = $clog2(NCH);
    localparam logic [7:0]  SPUR_VEC = VEC_BASE + 8'(2 * NCH);

    logic           m1_r, m1_rr, iorq_r, iorq_rr;
    logic           m1_beg, iorq_beg, ack;
    logic [NCH-1:0] ena_q, ena_d, req_q, req_d, isr_q, isr_d;
    logic           win_vld_q, win_vld_d;
    logic [IW-1:0]  win_idx_q, win_idx_d;
    logic [NCH-1:0] blk, pend, ack_hit, eoi_clr;
    logic           pick_vld;
    logic [IW-1:0]  pick_idx;

    // Two-flop synchronisers for the asynchronous bus strobes; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_r    <= 1'b1;
            m1_rr   <= 1'b1;
            iorq_r  <= 1'b1;
            iorq_rr <= 1'b1;
        end else begin
            m1_r    <= m1_n;
            m1_rr   <= m1_r;
            iorq_r  <= iorq_n;
            iorq_rr <= iorq_r;
        end
    end

    assign m1_beg   = m1_rr & ~m1_r;
    assign iorq_beg = iorq_rr & ~iorq_r;
    // IORQ falling while M1 is (already) low marks the INTACK cycle.
    assign ack      = iorq_beg & ~m1_rr;

    // Nesting mask, pending set and fixed-priority pick of the lowest pending index.
    always_comb begin
        logic isr_seen;
        isr_seen = 1'b0;
        blk      = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            isr_seen = isr_seen | isr_q[i];
            blk[i]   = NEST & isr_seen;
        end
        pend = req_q & ena_q & ~blk;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(i);
            end
        end
    end

    // Acknowledged channel decode and EOI clear set (explicit mask or lowest in service).
    always_comb begin
        logic found;
        found   = 1'b0;
        ack_hit = '0;
        eoi_clr = '0;
        for (int i = 0; i < NCH; i++) begin
            ack_hit[i] = ack & win_vld_q & (win_idx_q == IW'(i));
            if (isr_q[i] && !found) begin
                eoi_clr[i] = 1'b1;
                found      = 1'b1;
            end
        end
        if (wr_mask != '0) begin
            eoi_clr = wr_mask;
        end
    end

    // Next-state for enable, request, in-service and latched winner.
    always_comb begin
        ena_d     = ena_q;
        req_d     = req_q;
        isr_d     = isr_q;
        win_vld_d = win_vld_q;
        win_idx_d = win_idx_q;
        for (int i = 0; i < NCH; i++) begin
            if (ena_wr && wr_mask[i]) begin
                ena_d[i] = wr_set;
            end
            // A fresh strobe wins over the ack clear so no request is lost.
            if (int_stbs[i]) begin
                req_d[i] = 1'b1;
            end else if (ack_hit[i]) begin
                req_d[i] = 1'b0;
            end else if (req_wr && wr_mask[i]) begin
                req_d[i] = wr_set;
            end
            if (!NEST) begin
                isr_d[i] = 1'b0;
            end else if (ack_hit[i]) begin
                isr_d[i] = 1'b1;
            end else if (eoi_wr && eoi_clr[i]) begin
                isr_d[i] = 1'b0;
            end
        end
        if (m1_beg) begin
            win_vld_d = pick_vld;
            win_idx_d = pick_idx;
        end
    end

    // Controller state and the registered INT_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_q     <= {{(NCH-1){1'b0}}, 1'b1};
            req_q     <= '0;
            isr_q     <= '0;
            win_vld_q <= 1'b0;
            win_idx_q <= '0;
            int_n     <= 1'b1;
        end else begin
            ena_q     <= ena_d;
            req_q     <= req_d;
            isr_q     <= isr_d;
            win_vld_q <= win_vld_d;
            win_idx_q <= win_idx_d;
            int_n     <= ~(|pend);
        end
    end

    assign int_vector = win_vld_q ? (VEC_BASE + 8'({win_idx_q, 1'b0})) : SPUR_VEC;
    assign ena_rd     = ena_q;
    assign req_rd     = req_q;
    assign isr_rd     = isr_q;

endmodule
